ir_queue: RTL and testbench

- Parametrised instruction register queue that replaces the single-entry IR.
- Buffers up to DEPTH fetched LC-3b instruction words together with their PCs.
- Presents combinational field decode of the head entry to control and datapath, using the same field slicing as the single IR.
- Sits between memory fetch and the control FSM, letting fetch run ahead of decode; supports flush on taken branch, JSR or TRAP.

---
 rtl/ir_queue.sv | 128 ++++++++++++
 tb/tb_ir_queue.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/ir_queue.sv
// Instruction register queue: circular buffer of DEPTH {word, pc} entries with head-entry field decode.
// Latency: a word pushed at edge N reaches the head at edge N when the queue was empty; there is no bypass.
// Backpressure: in_ready = (count < DEPTH), computed from registered state only; flush drops everything.
//
// Ports:
//   clk, rst_n          : clock; asynchronous active-low reset
//   flush               : discard all entries (synchronous, highest priority)
//   in_valid/in_ready   : fetch handshake with in_word and in_pc
//   out_valid/out_ready : consumer handshake; out_ready pops the head
//   count               : current occupancy
//   head_pc, opcode..   : head PC and decoded instruction fields (zero when empty)
module ir_queue #(
  parameter int DEPTH    = 4,
  parameter int PC_WIDTH = 16,
  parameter int CNT_W    = $clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                in_valid,
  input  logic [15:0]         in_word,
  input  logic [PC_WIDTH-1:0] in_pc,
  output logic                in_ready,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CNT_W-1:0]    count,
  output logic [PC_WIDTH-1:0] head_pc,
  output logic [3:0]          opcode,
  output logic [2:0]          dest,
  output logic [2:0]          src1,
  output logic [2:0]          src2,
  output logic [5:0]          offset6,
  output logic [8:0]          offset9,
  output logic [3:0]          imm4,
  output logic [4:0]          imm5,
  output logic [10:0]         imm11,
  output logic                sr2mux_sel,
  output logic                jsr_operation,
  output logic [1:0]          shf_operation,
  output logic [7:0]          trapvect8
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  typedef struct packed {
    logic [15:0]         word;
    logic [PC_WIDTH-1:0] pc;
  } entry_t;

  entry_t           mem_q [DEPTH];
  entry_t           head;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push, pop;

  // Both handshakes depend only on count_q, so out_ready never reaches in_ready.
  assign in_ready  = (count_q < DEPTH_C);
  assign out_valid = (count_q != '0);
  assign count     = count_q;

  // Flush wins over both handshakes; a push in the flush cycle is dropped.
  assign push = in_valid && in_ready && !flush;
  assign pop  = out_valid && out_ready && !flush;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage carries no reset: contents are only observed while counted as valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {in_word, in_pc};
    end
  end

  // Empty queue presents all-zero fields: opcode 0 is BR with nzp = 0, i.e. a no-op.
  always_comb begin
    head = '0;
    if (out_valid) head = mem_q[rd_ptr_q];
  end

  assign head_pc       = head.pc;
  assign opcode        = head.word[15:12];
  assign dest          = head.word[11:9];
  assign src1          = head.word[8:6];
  assign src2          = head.word[2:0];
  assign offset6       = head.word[5:0];
  assign offset9       = head.word[8:0];
  assign imm4          = head.word[3:0];
  assign imm5          = head.word[4:0];
  assign imm11         = head.word[10:0];
  assign sr2mux_sel    = head.word[5];
  assign jsr_operation = head.word[11];
  assign shf_operation = head.word[5:4];
  assign trapvect8     = head.word[7:0];

endmodule

// File: tb/tb_ir_queue.sv
module tb_ir_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [15:0] in_word;
  logic [15:0] in_pc;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  count;
  logic [15:0] head_pc;
  logic [3:0]  opcode;
  logic [2:0]  dest, src1, src2;
  logic [5:0]  offset6;
  logic [8:0]  offset9;
  logic [3:0]  imm4;
  logic [4:0]  imm5;
  logic [10:0] imm11;
  logic        sr2mux_sel, jsr_operation;
  logic [1:0]  shf_operation;
  logic [7:0]  trapvect8;

  ir_queue #(.DEPTH(DEPTH), .PC_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_word(in_word), .in_pc(in_pc), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .count(count),
    .head_pc(head_pc), .opcode(opcode), .dest(dest), .src1(src1), .src2(src2),
    .offset6(offset6), .offset9(offset9), .imm4(imm4), .imm5(imm5), .imm11(imm11),
    .sr2mux_sel(sr2mux_sel), .jsr_operation(jsr_operation),
    .shf_operation(shf_operation), .trapvect8(trapvect8)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [15:0] w;
    logic [15:0] pc;
    logic        ordy;
    logic        fl;
    int          exp_cnt;
  } vec_t;

  typedef struct {
    logic [15:0] w;
    logic [15:0] pc;
  } ent_t;

  vec_t vecs[$];
  ent_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic iv, input logic [15:0] w, input logic ordy,
                     input logic fl, input int exp_cnt);
    vec_t v;
    v.iv = iv; v.w = w; v.pc = 16'h3000 + {w[14:0], 1'b0};
    v.ordy = ordy; v.fl = fl; v.exp_cnt = exp_cnt;
    vecs.push_back(v);
  endtask

  // Compare every head output against the front of the scoreboard (zeros when empty).
  task automatic check_head(input string tag);
    logic [15:0] w, pc;
    w  = (sb.size() != 0) ? sb[0].w  : 16'h0;
    pc = (sb.size() != 0) ? sb[0].pc : 16'h0;
    chk({tag, " out_valid"}, 32'(out_valid), 32'(sb.size() != 0));
    chk({tag, " in_ready"},  32'(in_ready),  32'(sb.size() < DEPTH));
    chk({tag, " count"},     32'(count),     32'(sb.size()));
    chk({tag, " head_pc"},   32'(head_pc),   32'(pc));
    chk({tag, " opcode"},    32'(opcode),    32'((w >> 12) & 16'hF));
    chk({tag, " dest"},      32'(dest),      32'((w >> 9) & 16'h7));
    chk({tag, " src1"},      32'(src1),      32'((w >> 6) & 16'h7));
    chk({tag, " src2"},      32'(src2),      32'(w & 16'h7));
    chk({tag, " offset6"},   32'(offset6),   32'(w & 16'h3F));
    chk({tag, " offset9"},   32'(offset9),   32'(w & 16'h1FF));
    chk({tag, " imm4"},      32'(imm4),      32'(w & 16'hF));
    chk({tag, " imm5"},      32'(imm5),      32'(w & 16'h1F));
    chk({tag, " imm11"},     32'(imm11),     32'(w & 16'h7FF));
    chk({tag, " sr2mux"},    32'(sr2mux_sel),    32'((w >> 5) & 16'h1));
    chk({tag, " jsr"},       32'(jsr_operation), 32'((w >> 11) & 16'h1));
    chk({tag, " shf"},       32'(shf_operation), 32'((w >> 4) & 16'h3));
    chk({tag, " trapvect8"}, 32'(trapvect8),     32'(w & 16'hFF));
  endtask

  // One cycle: check head at negedge, drive, update the model, check count after the edge.
  task automatic step(input vec_t v, input int idx);
    bit do_pop, do_push;
    ent_t e;
    @(negedge clk);
    check_head($sformatf("v%0d pre", idx));
    in_valid  = v.iv;
    in_word   = v.w;
    in_pc     = v.pc;
    out_ready = v.ordy;
    flush     = v.fl;
    if (v.fl) begin
      sb.delete();
    end else begin
      do_pop  = (sb.size() != 0) && v.ordy;
      do_push = v.iv && (sb.size() < DEPTH);
      if (do_pop) void'(sb.pop_front());
      if (do_push) begin
        e.w = v.w; e.pc = v.pc;
        sb.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    chk($sformatf("v%0d count", idx), 32'(count), 32'(v.exp_cnt));
  endtask

  task automatic idle();
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_word = '0; in_pc = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset state, hand-written constants.
    @(negedge clk);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst in_ready",  32'(in_ready),  32'd1);
    chk("rst count",     32'(count),     32'd0);
    chk("rst opcode",    32'(opcode),    32'd0);
    chk("rst head_pc",   32'(head_pc),   32'd0);

    // Single push of 0x1A42 at pc 0x3000.
    begin
      vec_t v;
      v.iv = 1'b1; v.w = 16'h1A42; v.pc = 16'h3000; v.ordy = 1'b0; v.fl = 1'b0; v.exp_cnt = 1;
      step(v, 999);
    end
    idle();
    @(negedge clk);
    chk("p1 out_valid", 32'(out_valid),  32'd1);
    chk("p1 opcode",    32'(opcode),     32'h1);
    chk("p1 dest",      32'(dest),       32'd5);
    chk("p1 src1",      32'(src1),       32'd1);
    chk("p1 sr2mux",    32'(sr2mux_sel), 32'd0);
    chk("p1 src2",      32'(src2),       32'd2);
    chk("p1 head_pc",   32'(head_pc),    32'h3000);
    chk("p1 count",     32'(count),      32'd1);

    // Table: {in_valid, word, out_ready, flush, expected count after the edge}.
    add(0, 16'h0000, 1, 0, 0);                      // pop 0x1A42
    for (int i = 1; i <= 4; i++) add(1, 16'(i), 0, 0, i);
    add(1, 16'h0005, 0, 0, 4);                      // full: ignored
    for (int i = 3; i >= 0; i--) add(0, 16'h0000, 1, 0, i);
    add(0, 16'h0000, 1, 0, 0);                      // pop while empty: ignored
    for (int i = 0; i < 4; i++) add(1, 16'h0010 + 16'(i), 0, 0, i + 1);
    add(1, 16'h0014, 1, 0, 3);                      // full: pop only
    add(1, 16'h0014, 0, 0, 4);                      // held word now accepted
    for (int k = 0; k < 5; k++) begin               // interleave past 2*DEPTH entries
      add(1, 16'h0015 + 16'(k), 1, 0, 3);
      add(1, 16'h0015 + 16'(k), 0, 0, 4);
    end
    add(0, 16'h0000, 1, 0, 3);
    add(0, 16'h0000, 1, 0, 2);
    add(1, 16'h0077, 1, 1, 0);                      // flush beats push and pop
    add(1, 16'hF025, 0, 0, 1);
    for (int i = 0; i < vecs.size(); i++) step(vecs[i], i);
    idle();

    @(negedge clk);
    chk("trap opcode",    32'(opcode),    32'hF);
    chk("trap trapvect8", 32'(trapvect8), 32'h25);
    check_head("trap");

    // Bring to three entries, then reset asynchronously while clk is high.
    begin
      vec_t v;
      v.iv = 1'b1; v.w = 16'h1234; v.pc = 16'h4000; v.ordy = 1'b0; v.fl = 1'b0; v.exp_cnt = 2;
      step(v, 1000);
      v.w = 16'h5678; v.pc = 16'h4002; v.exp_cnt = 3;
      step(v, 1001);
    end
    idle();
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst count",     32'(count),     32'd0);
    chk("arst out_valid", 32'(out_valid), 32'd0);
    chk("arst in_ready",  32'(in_ready),  32'd1);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_head("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
